// File: rtl/serial_demux_deser.sv
// serial_demux_deser: steers a serial bit stream into the slots of a
// parallel word using an internal slot counter as the select. Completed words
// are presented on a registered output with a valid/ready handshake.

// One assembly bit. A write takes priority over a clear, so a restart can
// clear the whole word and load slot 0 on the same edge.
module sdd_slot_cell (
  input  logic clock,
  input  logic resetn,
  input  logic clr_i,
  input  logic we_i,
  input  logic d_i,
  output logic q_o
);
  // assembly bit storage
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)    q_o <= 1'b0;
    else if (we_i)  q_o <= d_i;
    else if (clr_i) q_o <= 1'b0;
  end
endmodule

module serial_demux_deser #(
  parameter  int WIDTH     = 4,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int SW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             start,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic [SW-1:0]    slot,
  output logic             overrun
);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic [SW-1:0]      wr_slot;
  logic               wr, clr, complete;
  logic [WIDTH-1:0]   asm_q, we_vec, word;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;

  // state and slot counter registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // frame sequencing: start/restart, per-slot writes and completion
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    clr      = 1'b0;
    wr       = 1'b0;
    wr_slot  = '0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        // bits without start are dropped while idle
        if (in_valid && start) begin
          clr     = 1'b1;
          wr      = 1'b1;
          slot_d  = SW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (in_valid) begin
          if (start) begin
            // restart wins even on the last slot; partial word is discarded
            clr    = 1'b1;
            wr     = 1'b1;
            slot_d = SW'(1);
          end else if (slot_q == LAST) begin
            // last bit goes straight into the output word, assembly clears
            complete = 1'b1;
            clr      = 1'b1;
            slot_d   = '0;
            state_d  = IDLE;
          end else begin
            wr      = 1'b1;
            wr_slot = slot_q;
            slot_d  = slot_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // one cell per physical bit; logical slot maps through MSB_FIRST
  for (genvar p = 0; p < WIDTH; p++) begin : g_slot
    localparam int LOGI = MSB_FIRST ? (WIDTH - 1 - p) : p;
    assign we_vec[p] = wr && (wr_slot == SW'(LOGI));
    assign word[p]   = (slot_q == SW'(LOGI)) ? in_bit : asm_q[p];
    sdd_slot_cell u_cell (
      .clock  (clock),
      .resetn (resetn),
      .clr_i  (clr),
      .we_i   (we_vec[p]),
      .d_i    (in_bit),
      .q_o    (asm_q[p])
    );
  end

  // output holding register and handshake; a full, stalled buffer drops
  // the new word and flags overrun
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == SHIFT);
  assign slot      = slot_q;

endmodule

// File: tb/tb_serial_demux_deser.sv
// Bench: two instances (LSB-first and MSB-first) share one stimulus stream and
// are compared every cycle against a frame-level reference model.
module tb_serial_demux_deser;
  localparam int W = 4;

  logic clock = 1'b0, resetn = 1'b0;
  logic in_valid = 1'b0, in_bit = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [W-1:0] od0, od1;
  logic ov0, ov1, bz0, bz1, orun0, orun1;
  logic [1:0] sl0, sl1;

  int n_tests = 0, n_fail = 0;

  // reference model state
  int           frame[$];
  logic [W-1:0] m_d0, m_d1;
  logic         m_v, m_ovr;

  always #5 clock = ~clock;

  serial_demux_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_bit(in_bit),
    .start(start), .out_ready(out_ready), .out_data(od0), .out_valid(ov0),
    .busy(bz0), .slot(sl0), .overrun(orun0));

  serial_demux_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_bit(in_bit),
    .start(start), .out_ready(out_ready), .out_data(od1), .out_valid(ov1),
    .busy(bz1), .slot(sl1), .overrun(orun1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    m_d0 = '0; m_d1 = '0; m_v = 1'b0; m_ovr = 1'b0;
  endtask

  // frame-level model: collect bits in a queue, build the word when W arrive
  task automatic model_edge();
    bit           cmp = 1'b0;
    logic [W-1:0] w0 = '0, w1 = '0;
    if (in_valid) begin
      if (start) begin
        frame.delete();
        frame.push_back(int'(in_bit));
      end else if (frame.size() > 0) begin
        frame.push_back(int'(in_bit));
        if (frame.size() == W) begin
          cmp = 1'b1;
          for (int i = 0; i < W; i++) begin
            w0[i]     = frame[i][0];
            w1[W-1-i] = frame[i][0];
          end
          frame.delete();
        end
      end
    end
    if (cmp) begin
      if (!m_v || out_ready) begin
        m_d0 = w0; m_d1 = w1; m_v = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_v && out_ready) begin
      m_v = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("lsb_data",  32'(od0),   32'(m_d0));
    chk("msb_data",  32'(od1),   32'(m_d1));
    chk("lsb_valid", 32'(ov0),   32'(m_v));
    chk("msb_valid", 32'(ov1),   32'(m_v));
    chk("lsb_busy",  32'(bz0),   32'(frame.size() > 0));
    chk("msb_busy",  32'(bz1),   32'(frame.size() > 0));
    chk("lsb_slot",  32'(sl0),   32'(frame.size()));
    chk("msb_slot",  32'(sl1),   32'(frame.size()));
    chk("lsb_ovr",   32'(orun0), 32'(m_ovr));
    chk("msb_ovr",   32'(orun1), 32'(m_ovr));
  endtask

  task automatic step(input logic v, input logic b, input logic s);
    @(negedge clock);
    in_valid = v; in_bit = b; start = s;
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0; in_valid = 1'b0; start = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // w[0] is sent first, with start
  task automatic send_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) step(1'b1, w[i], i == 0);
  endtask

  int busy_cnt;

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1'b1;

    // reset mid-frame after two bits
    out_ready = 1'b1;
    step(1, 1, 1);
    step(1, 0, 0);
    do_reset();
    chk("rst_data", 32'(od0), 32'h0);
    chk("rst_busy", 32'(bz0), 32'h0);
    chk("rst_slot", 32'(sl0), 32'h0);
    send_frame(4'b1101);
    chk("rst_frame_lsb", 32'(od0), 32'hD);
    chk("rst_frame_msb", 32'(od1), 32'hB);

    // basic LSB-first / MSB-first, slot stepping and busy length
    do_reset();
    out_ready = 1'b1;
    busy_cnt = 0;
    step(1, 1, 1); chk("slot_a", 32'(sl0), 32'd1); busy_cnt += int'(bz0);
    step(1, 0, 0); chk("slot_b", 32'(sl0), 32'd2); busy_cnt += int'(bz0);
    step(1, 1, 0); chk("slot_c", 32'(sl0), 32'd3); busy_cnt += int'(bz0);
    step(1, 1, 0); chk("slot_d", 32'(sl0), 32'd0); busy_cnt += int'(bz0);
    chk("busy_cycles", 32'(busy_cnt), 32'd3);
    chk("basic_valid", 32'(ov0), 32'd1);
    chk("basic_lsb", 32'(od0), 32'hD);
    chk("basic_msb", 32'(od1), 32'hB);
    step(0, 0, 0);
    chk("basic_pulse", 32'(ov0), 32'd0);

    // gapped in_valid
    step(1, 1, 1); step(0, 0, 0);
    step(1, 0, 0); step(0, 1, 1); step(0, 0, 0);
    step(1, 1, 0); step(0, 0, 0);
    step(1, 1, 0);
    chk("gap_lsb", 32'(od0), 32'hD);
    chk("gap_msb", 32'(od1), 32'hB);

    // idle bit without start is ignored; restart mid-frame
    do_reset();
    step(1, 1, 0);
    chk("ign_slot", 32'(sl0), 32'd0);
    chk("ign_busy", 32'(bz0), 32'd0);
    step(1, 1, 1); step(1, 1, 0);
    step(1, 0, 1); step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
    chk("restart_lsb", 32'(od0), 32'h4);
    chk("restart_msb", 32'(od1), 32'h2);
    chk("restart_ovr", 32'(orun0), 32'd0);

    // back-to-back accept
    do_reset();
    out_ready = 1'b1;
    send_frame(4'h3);
    chk("b2b_v1", 32'(ov0), 32'd1);
    chk("b2b_d1", 32'(od0), 32'h3);
    send_frame(4'hC);
    chk("b2b_v2", 32'(ov0), 32'd1);
    chk("b2b_d2", 32'(od0), 32'hC);
    chk("b2b_ovr", 32'(orun0), 32'd0);

    // backpressure and overrun
    do_reset();
    out_ready = 1'b0;
    send_frame(4'hA);
    send_frame(4'h5);
    chk("bp_data", 32'(od0), 32'hA);
    chk("bp_ovr", 32'(orun0), 32'd1);
    out_ready = 1'b1;
    step(0, 0, 0);
    chk("bp_drain", 32'(ov0), 32'd0);
    chk("bp_hold", 32'(od0), 32'hA);
    chk("bp_sticky", 32'(orun0), 32'd1);

    // random traffic
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        out_ready = ($urandom_range(0, 9) < 6);
        step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 19) < 3);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
